mem_add_engine: RTL and testbench

Burst memory engine inside `accel` that streams a vector of 64-bit words from memory, adds a host-supplied constant to each word, and writes the results back to a second buffer. It drives the `mem_*` request/write/read channel toward the memory DPI. It takes its command (start, lengths, addresses, constant) from the accelerator's host-register block and reports busy/done/cycle count back to it. Transfers are split into bursts of at most `MAX_BURST` beats staged in an internal buffer.

---
 rtl/mem_add_engine_if.sv | 46 ++++
 rtl/mem_add_engine.sv | 186 ++++++++++++++++++
 tb/tb_mem_add_engine.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_add_engine_if.sv
// Command and memory-channel bundle for mem_add_engine.
//   cmd_*          : host command (start pulse, length, source/destination address, addend)
//   busy/done/cycles : status back to the host register block
//   mem_req_*      : one-cycle burst request (opcode 0 = read, 1 = write)
//   mem_wr_*       : write beats, always accepted by memory
//   mem_rd_*       : read beats from memory, dequeued with mem_rd_ready
// Modports: master = engine side, slave = host/memory side.
interface mem_add_engine_if #(
  parameter int unsigned MEM_LEN_BITS  = 8,
  parameter int unsigned MEM_ADDR_BITS = 64,
  parameter int unsigned MEM_DATA_BITS = 64
);
  logic                     cmd_start;
  logic [MEM_LEN_BITS-1:0]  cmd_len;
  logic [MEM_ADDR_BITS-1:0] cmd_rd_addr;
  logic [MEM_ADDR_BITS-1:0] cmd_wr_addr;
  logic [MEM_DATA_BITS-1:0] cmd_const;
  logic                     busy;
  logic                     done;
  logic [31:0]              cycles;
  logic                     mem_req_valid;
  logic                     mem_req_opcode;
  logic [MEM_LEN_BITS-1:0]  mem_req_len;
  logic [MEM_ADDR_BITS-1:0] mem_req_addr;
  logic                     mem_wr_valid;
  logic [MEM_DATA_BITS-1:0] mem_wr_bits;
  logic                     mem_rd_valid;
  logic [MEM_DATA_BITS-1:0] mem_rd_bits;
  logic                     mem_rd_ready;

  modport master (
    input  cmd_start, cmd_len, cmd_rd_addr, cmd_wr_addr, cmd_const,
    output busy, done, cycles,
    output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    output mem_wr_valid, mem_wr_bits, mem_rd_ready,
    input  mem_rd_valid, mem_rd_bits
  );

  modport slave (
    output cmd_start, cmd_len, cmd_rd_addr, cmd_wr_addr, cmd_const,
    input  busy, done, cycles,
    input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    input  mem_wr_valid, mem_wr_bits, mem_rd_ready,
    output mem_rd_valid, mem_rd_bits
  );
endinterface

// File: rtl/mem_add_engine.sv
// Burst add engine: reads cmd_len 64-bit words from cmd_rd_addr, adds cmd_const to each and
// writes the results to cmd_wr_addr, in bursts of at most MAX_BURST beats staged in a buffer.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, clears all state
//   bus   : mem_add_engine_if.master (command, status and memory channel)
// Build option: define MEM_ADD_ENGINE_SAT_EN to saturate each add to all-ones on unsigned
// overflow; otherwise the add wraps.
module mem_add_engine #(
  parameter int unsigned MEM_LEN_BITS  = 8,
  parameter int unsigned MEM_ADDR_BITS = 64,
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned MAX_BURST     = 16
) (
  input logic              clock,
  input logic              reset,
  mem_add_engine_if.master bus
);
  localparam int unsigned LenW = MEM_LEN_BITS + 1;  // holds MAX_BURST even when it is 2^LEN
  localparam int unsigned IdxW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {StIdle, StRdReq, StRdData, StWrReq, StWrData, StDone} state_e;

  state_e                   state_q, state_d;
  logic [MEM_LEN_BITS-1:0]  remaining_q, remaining_d;
  logic [MEM_ADDR_BITS-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [MEM_DATA_BITS-1:0] const_q, const_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic [31:0]              cycles_q, cycles_d;
  logic                     req_valid_q, req_valid_d, req_op_q, req_op_d;
  logic [MEM_LEN_BITS-1:0]  req_len_q, req_len_d;
  logic [MEM_ADDR_BITS-1:0] req_addr_q, req_addr_d;
  logic                     wr_valid_q, wr_valid_d;
  logic [MEM_DATA_BITS-1:0] wr_bits_q, wr_bits_d;
  logic [MEM_DATA_BITS-1:0] beat_buf_q [MAX_BURST];

  logic                     buf_we;
  logic [MEM_DATA_BITS-1:0] sum;
  logic [LenW-1:0]          blen;
  logic                     last_beat;
  logic [MEM_ADDR_BITS-1:0] burst_bytes;

  assign blen        = ({1'b0, remaining_q} > LenW'(MAX_BURST)) ? LenW'(MAX_BURST)
                                                                 : {1'b0, remaining_q};
  assign last_beat   = (LenW'(idx_q) == blen - LenW'(1));
  assign burst_bytes = MEM_ADDR_BITS'(blen) << 3;

`ifdef MEM_ADD_ENGINE_SAT_EN
  logic [MEM_DATA_BITS:0] sum_full;
  assign sum_full = {1'b0, bus.mem_rd_bits} + {1'b0, const_q};
  assign sum      = sum_full[MEM_DATA_BITS] ? '1 : sum_full[MEM_DATA_BITS-1:0];
`else
  assign sum      = bus.mem_rd_bits + const_q;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    const_d     = const_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cycles_d    = (busy_q && (cycles_q != '1)) ? cycles_q + 32'd1 : cycles_q;
    req_valid_d = 1'b0;
    req_op_d    = 1'b0;
    req_len_d   = '0;
    req_addr_d  = '0;
    wr_valid_d  = 1'b0;
    wr_bits_d   = '0;
    buf_we      = 1'b0;
    // busy drops on the edge that ends the done pulse
    if (done_q) busy_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // busy_q is still high during the done cycle, so a start there is ignored too
        if (bus.cmd_start && !busy_q) begin
          remaining_d = bus.cmd_len;
          rd_addr_d   = bus.cmd_rd_addr;
          wr_addr_d   = bus.cmd_wr_addr;
          const_d     = bus.cmd_const;
          idx_d       = '0;
          busy_d      = 1'b1;
          cycles_d    = '0;
          state_d     = (bus.cmd_len == '0) ? StDone : StRdReq;
        end
      end
      StRdReq: begin
        req_valid_d = 1'b1;
        req_len_d   = MEM_LEN_BITS'(blen - LenW'(1));
        req_addr_d  = rd_addr_q;
        idx_d       = '0;
        state_d     = StRdData;
      end
      StRdData: begin
        if (bus.mem_rd_valid) begin
          buf_we = 1'b1;
          if (last_beat) begin
            idx_d   = '0;
            state_d = StWrReq;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StWrReq: begin
        req_valid_d = 1'b1;
        req_op_d    = 1'b1;
        req_len_d   = MEM_LEN_BITS'(blen - LenW'(1));
        req_addr_d  = wr_addr_q;
        state_d     = StWrData;
      end
      StWrData: begin
        // beats are registered, so they trail the request pulse by one cycle
        wr_valid_d = 1'b1;
        wr_bits_d  = beat_buf_q[idx_q];
        if (last_beat) begin
          idx_d       = '0;
          rd_addr_d   = rd_addr_q + burst_bytes;
          wr_addr_d   = wr_addr_q + burst_bytes;
          remaining_d = remaining_q - MEM_LEN_BITS'(blen);
          state_d     = (remaining_d != '0) ? StRdReq : StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      const_q     <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cycles_q    <= '0;
      req_valid_q <= 1'b0;
      req_op_q    <= 1'b0;
      req_len_q   <= '0;
      req_addr_q  <= '0;
      wr_valid_q  <= 1'b0;
      wr_bits_q   <= '0;
      for (int i = 0; i < MAX_BURST; i++) beat_buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      const_q     <= const_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cycles_q    <= cycles_d;
      req_valid_q <= req_valid_d;
      req_op_q    <= req_op_d;
      req_len_q   <= req_len_d;
      req_addr_q  <= req_addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_bits_q   <= wr_bits_d;
      if (buf_we) beat_buf_q[idx_q] <= sum;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.cycles         = cycles_q;
  assign bus.mem_req_valid  = req_valid_q;
  assign bus.mem_req_opcode = req_op_q;
  assign bus.mem_req_len    = req_len_q;
  assign bus.mem_req_addr   = req_addr_q;
  assign bus.mem_wr_valid   = wr_valid_q;
  assign bus.mem_wr_bits    = wr_bits_q;
  assign bus.mem_rd_ready   = (state_q == StRdData);
endmodule

// File: tb/tb_mem_add_engine.sv
// Self-checking bench for mem_add_engine: a behavioural memory drives the read channel and
// records writes; expected bursts and results are derived from the command alone.
module tb_mem_add_engine;
  localparam int unsigned LB = 8;
  localparam int unsigned AB = 64;
  localparam int unsigned DB = 64;
  localparam int unsigned MB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_add_engine_if #(.MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB)) bus ();

  mem_add_engine #(
    .MEM_LEN_BITS (LB),
    .MEM_ADDR_BITS(AB),
    .MEM_DATA_BITS(DB),
    .MAX_BURST    (MB)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic        op;
    logic [7:0]  len;
    logic [63:0] addr;
  } req_t;

  req_t        req_log [$];
  logic [63:0] rdq [$];
  logic [63:0] mem [logic [63:0]];
  int          checks   = 0;
  int          errors   = 0;
  int          viol     = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          wr_left  = 0;
  logic [63:0] wr_ptr   = '0;
  bit          acc_flag = 1'b0;
  bit          prev_req = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_add(input logic [63:0] a, input logic [63:0] c);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, c};
`ifdef MEM_ADD_ENGINE_SAT_EN
    return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
`else
    return s[63:0];
`endif
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Memory model and protocol monitor, all at the falling edge.
  initial begin
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_bits  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rdq.delete();
        wr_left  = 0;
        acc_flag = 1'b0;
        prev_req = 1'b0;
        bus.mem_rd_valid = 1'b0;
      end else begin
        if (acc_flag) void'(rdq.pop_front());
        if (wr_left > 0) begin
          if (bus.mem_wr_valid) begin
            mem[wr_ptr] = bus.mem_wr_bits;
            wr_ptr      = wr_ptr + 64'd8;
            wr_left--;
          end else viol++;
        end else if (bus.mem_wr_valid) viol++;
        if (bus.mem_req_valid) begin
          req_log.push_back({bus.mem_req_opcode, bus.mem_req_len, bus.mem_req_addr});
          if (prev_req) viol++;
          if (!bus.mem_req_opcode) begin
            for (int i = 0; i <= int'(bus.mem_req_len); i++) begin
              logic [63:0] a;
              a = bus.mem_req_addr + 64'(8 * i);
              rdq.push_back(mem.exists(a) ? mem[a] : 64'h0);
            end
          end else begin
            wr_left = int'(bus.mem_req_len) + 1;
            wr_ptr  = bus.mem_req_addr;
          end
        end
        prev_req = bus.mem_req_valid;
        if (bus.mem_rd_ready && bus.mem_wr_valid) viol++;
        if (bus.done) begin
          done_cnt++;
          if (!bus.busy) viol++;
        end
        if (bus.busy) busy_cnt++;
        bus.mem_rd_valid = (rdq.size() > 0) && ($urandom_range(0, 3) != 0);
        bus.mem_rd_bits  = (rdq.size() > 0) ? rdq[0] : rand64();
        acc_flag = bus.mem_rd_valid && bus.mem_rd_ready;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int done_base;

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_cycles"}, 64'(bus.cycles), 64'd0);
    chk({tag, "_req"}, {bus.mem_req_valid, bus.mem_req_opcode, bus.mem_req_len}, 64'd0);
    chk({tag, "_req_addr"}, bus.mem_req_addr, 64'd0);
    chk({tag, "_wr"}, 64'(bus.mem_wr_valid), 64'd0);
    chk({tag, "_wr_bits"}, bus.mem_wr_bits, 64'd0);
    chk({tag, "_rd_ready"}, 64'(bus.mem_rd_ready), 64'd0);
  endtask

  task automatic preload(input int len, input logic [63:0] rd);
    for (int i = 0; i < len; i++)
      if (!mem.exists(rd + 64'(8 * i))) mem[rd + 64'(8 * i)] = rand64();
  endtask

  task automatic start_cmd(input int len, input logic [63:0] rd, input logic [63:0] wr,
                           input logic [63:0] c);
    @(negedge clk);
    bus.cmd_len     = LB'(len);
    bus.cmd_rd_addr = rd;
    bus.cmd_wr_addr = wr;
    bus.cmd_const   = c;
    bus.cmd_start   = 1'b1;
    done_base       = done_cnt;
    busy_cnt        = 0;
    @(negedge clk);
    bus.cmd_start   = 1'b0;
    // later field changes must not affect the running command
    bus.cmd_len     = LB'($urandom);
    bus.cmd_rd_addr = rand64();
    bus.cmd_wr_addr = rand64();
    bus.cmd_const   = rand64();
    chk("busy_rise", 64'(bus.busy), 64'd1);
    if (len != 0) begin
      @(negedge clk);
      chk("first_req", {62'd0, bus.mem_req_valid, bus.mem_req_opcode}, 64'd2);
    end
  endtask

  task automatic finish_cmd(input int len, input logic [63:0] rd, input logic [63:0] wr,
                            input logic [63:0] c);
    int   n;
    int   off;
    int   b;
    int   k;
    req_t exp_q [$];
    n = 0;
    while (done_cnt == done_base && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done_cnt != done_base), 64'd1);
    repeat (2) @(negedge clk);
    chk("done_once", 64'(done_cnt - done_base), 64'd1);
    chk("busy_fall", 64'(bus.busy), 64'd0);
    chk("cycles", 64'(bus.cycles), 64'(busy_cnt));
    chk("protocol", 64'(viol), 64'd0);
    chk("rd_drained", 64'(rdq.size()), 64'd0);
    off = 0;
    while (off < len) begin
      b = (len - off > int'(MB)) ? int'(MB) : len - off;
      exp_q.push_back({1'b0, 8'(b - 1), rd + 64'(8 * off)});
      exp_q.push_back({1'b1, 8'(b - 1), wr + 64'(8 * off)});
      off += b;
    end
    chk("req_count", 64'(req_log.size()), 64'(exp_q.size()));
    k = (req_log.size() < exp_q.size()) ? req_log.size() : exp_q.size();
    for (int i = 0; i < k; i++) begin
      chk("req_op", 64'(req_log[i].op), 64'(exp_q[i].op));
      chk("req_len", 64'(req_log[i].len), 64'(exp_q[i].len));
      chk("req_addr", req_log[i].addr, exp_q[i].addr);
    end
    for (int i = 0; i < len; i++) begin
      logic [63:0] wa;
      wa = wr + 64'(8 * i);
      chk("wr_data", mem.exists(wa) ? mem[wa] : 64'hx, ref_add(mem[rd + 64'(8 * i)], c));
    end
    req_log.delete();
  endtask

  task automatic run_cmd(input int len, input logic [63:0] rd, input logic [63:0] wr,
                         input logic [63:0] c);
    preload(len, rd);
    start_cmd(len, rd, wr, c);
    finish_cmd(len, rd, wr, c);
  endtask

  initial begin
    logic [63:0] c;
    bus.cmd_start   = 1'b0;
    bus.cmd_len     = '0;
    bus.cmd_rd_addr = '0;
    bus.cmd_wr_addr = '0;
    bus.cmd_const   = '0;
    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single beat
    mem[64'h100] = 64'd7;
    run_cmd(1, 64'h100, 64'h200, 64'd5);
    chk("single_value", mem[64'h200], 64'd12);

    // multi-burst: 16 + 16 + 8
    mem.delete();
    run_cmd(40, 64'h1000, 64'h8000, rand64());

    // zero length: busy two cycles, one done, no requests
    @(negedge clk);
    bus.cmd_len   = '0;
    bus.cmd_start = 1'b1;
    done_base     = done_cnt;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    chk("zero_busy1", {62'd0, bus.busy, bus.done}, 64'd2);
    @(negedge clk);
    chk("zero_done", {62'd0, bus.busy, bus.done}, 64'd3);
    @(negedge clk);
    chk("zero_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("zero_cycles", 64'(bus.cycles), 64'd2);
    chk("zero_no_req", 64'(req_log.size()), 64'd0);
    chk("zero_done_once", 64'(done_cnt - done_base), 64'd1);

    // overflow
    mem.delete();
    mem[64'h300] = 64'hFFFF_FFFF_FFFF_FFFE;
    run_cmd(1, 64'h300, 64'h400, 64'd3);
`ifdef MEM_ADD_ENGINE_SAT_EN
    chk("overflow_value", mem[64'h400], 64'hFFFF_FFFF_FFFF_FFFF);
`else
    chk("overflow_value", mem[64'h400], 64'h1);
`endif

    // start while busy is ignored
    mem.delete();
    c = rand64();
    preload(20, 64'h2000);
    start_cmd(20, 64'h2000, 64'h9000, c);
    repeat (4) @(negedge clk);
    bus.cmd_len     = 8'd3;
    bus.cmd_rd_addr = 64'h7000;
    bus.cmd_wr_addr = 64'hA000;
    bus.cmd_start   = 1'b1;
    @(negedge clk);
    bus.cmd_start   = 1'b0;
    finish_cmd(20, 64'h2000, 64'h9000, c);
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", 64'(bus.busy), 64'd0);

    // reset during the read phase aborts without done
    mem.delete();
    preload(40, 64'h3000);
    start_cmd(40, 64'h3000, 64'hB000, rand64());
    repeat (3) @(negedge clk);
    done_base = done_cnt;
    #2 rst_n = 1'b0;
    #1 chk_zero("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_no_done", 64'(done_cnt - done_base), 64'd0);
    req_log.delete();
    viol = 0;
    mem.delete();
    run_cmd(25, 64'h4000, 64'hC000, rand64());

    // address wrap
    mem.delete();
    run_cmd(10, 64'hFFFF_FFFF_FFFF_FFE0, 64'h5000, rand64());

    // random commands
    for (int t = 0; t < 5; t++) begin
      logic [63:0] rd;
      mem.delete();
      rd = rand64() & ~64'h7;
      run_cmd(int'($urandom_range(1, 70)), rd, rd + 64'h1_0000_0000, rand64());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
